// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bundle: decode/execute hazard inputs and the
// pipeline-register enable/flush controls, plus the stall counter.
interface hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        ex_md_start;
    logic        ex_md_div;
    logic        ex_branch_taken;

    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_en;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        md_busy;
    logic        md_done;
    logic [31:0] stall_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               ex_md_start, ex_md_div, ex_branch_taken,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_flush, md_busy, md_done, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               ex_md_start, ex_md_div, ex_branch_taken,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_flush, md_busy, md_done, stall_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline control: load-use stall, taken-branch squash, mult/div freeze
// and a saturating frozen-cycle counter.
//
// state | meaning
// RUN   | normal flow; evaluates mult/div start, branch, load-use
// MD    | mult/div occupies EX; counter counts remaining frozen cycles
module hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 33,
    parameter int CNT_W       = 6
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);
    typedef enum logic {RUN, MD} state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_cnt_q;

    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic ex_mem_flush, md_busy, md_done;
    logic load_use;

    assign load_use = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                      ((hz.ex_rt == hz.id_rs) ||
                       (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!pc_en && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        md_busy      = 1'b0;
        md_done      = 1'b0;

        case (state_q)
            RUN: begin
                if (hz.ex_md_start) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_flush = 1'b1;
                    md_busy      = 1'b1;
                    cnt_d        = hz.ex_md_div ? DIV_LOAD : MULT_LOAD;
                    state_d      = MD;
                end else if (hz.ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            MD: begin
                if (cnt_q != '0) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_flush = 1'b1;
                    md_busy      = 1'b1;
                    cnt_d        = cnt_q - 1'b1;
                end else begin
                    // release: mult/div result moves on, no bubble behind it
                    md_done = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (!rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            md_busy      = 1'b0;
            md_done      = 1'b0;
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.if_id_en     = if_id_en;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_en     = id_ex_en;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.ex_mem_flush = ex_mem_flush;
    assign hz.md_busy      = md_busy;
    assign hz.md_done      = md_done;
    assign hz.stall_count  = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random stimulus, checked
// against a cycle-level model of the pipeline control rules.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(33), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    always #5 clk = ~clk;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush, md_busy, md_done}
    localparam logic [7:0] O_RST = 8'b0011_1100;
    localparam logic [7:0] O_DEF = 8'b1101_0000;
    localparam logic [7:0] O_FRZ = 8'b0000_0110;
    localparam logic [7:0] O_REL = 8'b1101_0001;
    localparam logic [7:0] O_BR  = 8'b1111_1000;
    localparam logic [7:0] O_LU  = 8'b0001_1000;

    int errors = 0;
    int checks = 0;

    int              m_busy  = 0;   // frozen cycles still to come after this one
    bit              m_rel   = 1'b0;
    longint unsigned m_stall = 0;
    longint unsigned s0;

    logic [7:0] outs;
    assign outs = {hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_en,
                   hz.id_ex_flush, hz.ex_mem_flush, hz.md_busy, hz.md_done};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_out();
        bit lu;
        lu = hz.ex_mem_read && hz.ex_rt != 0 &&
             (hz.ex_rt == hz.id_rs || (hz.id_uses_rt && hz.ex_rt == hz.id_rt));
        if (!rst)               return O_RST;
        if (m_busy > 0)         return O_FRZ;
        if (m_rel)              return O_REL;
        if (hz.ex_md_start)     return O_FRZ;
        if (hz.ex_branch_taken) return O_BR;
        if (lu)                 return O_LU;
        return O_DEF;
    endfunction

    task automatic model_edge(input logic [7:0] exp);
        if (!rst) return;
        if (!exp[7] && m_stall != 64'hFFFF_FFFF) m_stall++;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) m_rel = 1'b1;
        end else if (m_rel) begin
            m_rel = 1'b0;
        end else if (hz.ex_md_start) begin
            m_busy = (hz.ex_md_div ? 33 : 4) - 1;
        end
    endtask

    task automatic step(input string tag);
        logic [7:0] exp;
        @(negedge clk);
        exp = model_out();
        check({tag, " outs"}, {24'd0, outs}, {24'd0, exp});
        check({tag, " stall"}, hz.stall_count, m_stall[31:0]);
        @(posedge clk);
        model_edge(exp);
        #1;
    endtask

    task automatic idle();
        hz.id_rs = 0; hz.id_rt = 0; hz.id_uses_rt = 0; hz.ex_mem_read = 0;
        hz.ex_rt = 0; hz.ex_md_start = 0; hz.ex_md_div = 0; hz.ex_branch_taken = 0;
    endtask

    initial begin
        idle();
        step("reset0");
        step("reset1");
        rst = 1'b1;

        // load-use on rs
        hz.ex_mem_read = 1; hz.ex_rt = 5; hz.id_rs = 5;
        step("lu_rs");
        idle();
        step("lu_clear");
        check("lu_count", hz.stall_count, 32'd1);

        // r0 never hazards; rt only matters when used
        hz.ex_mem_read = 1; hz.ex_rt = 0; hz.id_rs = 0;
        step("lu_r0");
        hz.ex_rt = 7; hz.id_rt = 7; hz.id_rs = 3; hz.id_uses_rt = 0;
        step("lu_rt_unused");
        hz.id_uses_rt = 1;
        step("lu_rt_used");
        idle();

        // multiply: 4 frozen + release
        s0 = m_stall;
        hz.ex_md_start = 1; hz.ex_md_div = 0;
        repeat (5) step("mul");
        idle();
        step("mul_after");
        check("mul_count", hz.stall_count, 32'(s0 + 4));

        // full divide: 33 frozen + release
        s0 = m_stall;
        hz.ex_md_start = 1; hz.ex_md_div = 1;
        repeat (34) step("div");
        idle();
        step("div_after");
        check("div_count", hz.stall_count, 32'(s0 + 33));

        // divide aborted by reset at frozen cycle 10
        hz.ex_md_start = 1; hz.ex_md_div = 1;
        repeat (10) step("div_abort");
        rst = 1'b0;
        m_busy = 0; m_rel = 1'b0; m_stall = 0;
        #1;
        check("rst_async", {24'd0, outs}, {24'd0, O_RST});
        step("div_rst");
        rst = 1'b1;
        idle();
        step("after_rst");
        check("after_rst_busy", {31'd0, hz.md_busy}, 32'd0);

        // branch beats load-use
        hz.ex_branch_taken = 1; hz.ex_mem_read = 1; hz.ex_rt = 9; hz.id_rs = 9;
        step("br_lu");
        idle();
        // mult/div start beats branch
        hz.ex_branch_taken = 1; hz.ex_md_start = 1; hz.ex_md_div = 0;
        repeat (5) step("br_md");
        idle();
        step("br_md_after");

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if (m_busy > 0 || m_rel) begin
                hz.ex_md_start = 1;
            end else begin
                hz.ex_md_start = ($urandom_range(0, 11) == 0);
                hz.ex_md_div   = ($urandom_range(0, 3) == 0);
            end
            hz.id_rs           = 5'($urandom_range(0, 5));
            hz.id_rt           = 5'($urandom_range(0, 5));
            hz.ex_rt           = 5'($urandom_range(0, 5));
            hz.id_uses_rt      = 1'($urandom);
            hz.ex_mem_read     = 1'($urandom);
            hz.ex_branch_taken = ($urandom_range(0, 4) == 0);
            step("rand");
        end
        idle();
        repeat (40) begin
            if (m_busy > 0 || m_rel) hz.ex_md_start = 1; else hz.ex_md_start = 0;
            step("drain");
        end
        idle();

        // saturation via preload
        hz.ex_mem_read = 1; hz.ex_rt = 4; hz.id_rs = 4;
        dut.stall_cnt_q = 32'hFFFF_FFFE;
        m_stall = 64'hFFFF_FFFE;
        repeat (3) step("sat");
        check("sat_hold", hz.stall_count, 32'hFFFF_FFFF);
        idle();
        step("sat_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
